// File: rtl/nextasic_pkg.sv
// rtl/nextasic_pkg.sv - shared constants and types for the NeXT ASIC serial link
//
// Purpose : frame width and receiver FSM state type shared by the link blocks.
// Ports   : none (package).

package nextasic_pkg;

  // Data bits per frame, not counting the start bit.
  localparam int RX_WIDTH = 40;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_t;

endpackage : nextasic_pkg

// File: rtl/receiver.sv
// rtl/receiver.sv - serial-to-parallel frame receiver for the NeXT ASIC serial link
//
// Purpose : waits on a low line for a single high start bit, then shifts in
//           WIDTH data bits MSB first (one per clk) and publishes the word on
//           a held parallel output with a one-cycle valid strobe.
// Ports   :
//   clk         in   1      sole clock, rising-edge sampling
//   reset_n     in   1      asynchronous active-low reset
//   sin         in   1      serial input, idle low, clk-synchronous source
//   data        out  WIDTH  last complete frame, bit WIDTH-1 = first data bit
//   data_valid  out  1      one-cycle pulse when data is updated
//   busy        out  1      high while a frame is being shifted in

module receiver
  import nextasic_pkg::*;
#(
  parameter int WIDTH = RX_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sin,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  rx_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Only WIDTH-1 bits are stored: the final bit goes straight from sin into
  // the output register on the completing edge.
  logic [WIDTH-2:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] word_next;

  assign word_next = {shift_q, sin};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        // The start bit itself is discarded; only the transition matters.
        if (sin) begin
          state_d = RECV;
          cnt_d   = '0;
        end
      end
      RECV: begin
        shift_d = word_next[WIDTH-2:0];
        if (cnt_q == LAST_BIT) begin
          data_d  = word_next;
          valid_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign busy       = (state_q == RECV);

endmodule : receiver

// File: tb/tb_receiver.sv
// tb/tb_receiver.sv - self-checking scoreboard bench for receiver

module tb_receiver;
  import nextasic_pkg::*;

  localparam int W = RX_WIDTH;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         sin;
  logic [W-1:0] data;
  logic         data_valid;
  logic         busy;

  receiver #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sin        (sin),
    .data       (data),
    .data_valid (data_valid),
    .busy       (busy)
  );

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] word;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] model_data = '0;
  int           n_assert = 0;
  int           n_fail   = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Monitor: every falling edge, compare outputs against the scoreboard head.
  always @(negedge clk) begin
    logic exp_v;
    logic exp_b;
    if (!reset_n) begin
      sb.delete();
      model_data = '0;
      check("rst_data", data, '0);
      check("rst_valid", W'(data_valid), '0);
      check("rst_busy", W'(busy), '0);
    end else begin
      exp_v = (sb.size() > 0) && (sb[0].cyc == cyc);
      exp_b = (sb.size() > 0) && (cyc >= sb[0].cyc - W) && (cyc < sb[0].cyc);
      check("data_valid", W'(data_valid), W'(exp_v));
      check("busy", W'(busy), W'(exp_b));
      if (exp_v) begin
        model_data = sb[0].word;
        void'(sb.pop_front());
      end
      check("data", data, model_data);
    end
  end

  task automatic drive(input logic b);
    @(posedge clk);
    #25 sin = b;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0);
  endtask

  // Start bit sampled one edge after it is driven; last data bit W edges later.
  task automatic send_frame(input logic [W-1:0] word, input int nbits);
    exp_t e;
    drive(1'b1);
    e.word = word;
    e.cyc  = cyc + W + 1;
    sb.push_back(e);
    for (int i = W - 1; i >= W - nbits; i--) drive(word[i]);
  endtask

  initial begin
    reset_n = 1'b0;
    sin     = 1'b0;
    for (int i = 0; i < 6; i++) drive(i[0]);
    @(posedge clk);
    #25 reset_n = 1'b1;
    sin = 1'b0;
    idle(3);

    send_frame(40'hA9F0AAAAA9, W);
    idle(4);
    send_frame(40'hA9F0AAAAA9, W);
    idle(2);

    send_frame(40'h0000000001, W);
    send_frame(40'hFFFFFFFFFF, W);
    idle(3);

    send_frame(40'h5555555555, 20);
    @(posedge clk);
    #25 reset_n = 1'b0;
    sin = 1'b0;
    repeat (3) @(posedge clk);
    #25 reset_n = 1'b1;
    idle(2);
    send_frame(40'h123456789A, W);

    idle(100);
    @(negedge clk);
    check("sb_empty", W'(sb.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_receiver
